mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, operand width; SHALL match the PE data ports.
REQ-002 Parameter ACC_W, default 32, accumulator width; SHALL match the PE acc ports.
REQ-003 Parameter LEN_W, default 8, width of the dot-product length field.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cfg_valid  in  1  / cfg_ready  out  1  / cfg_len  in  LEN_W  job-start handshake and element count.
REQ-007 op_valid  in  1  / op_ready  out  1  / op_a, op_b  in  DATA_W  operand stream handshake and data.
REQ-008 pe_a, pe_b  out  DATA_W  / pe_acc_in  out  ACC_W  / pe_val  out  1  / pe_rdy  out  1  drive the PE inputs.
REQ-009 pe_acc_out  in  ACC_W  / pe_val_out  in  1  PE registered accumulator and its valid.
REQ-010 res_valid  out  1  / res_ready  in  1  / res_data  out  ACC_W  result handshake and data.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-013 IDLE SHALL drive cfg_ready=1; in all other states cfg_ready SHALL be 0.
REQ-014 IDLE with cfg_valid=1 and cfg_len>0: latch cfg_len into remaining counter, set first-flag, go to RUN.
REQ-015 IDLE with cfg_valid=1 and cfg_len=0: load res_data=0 and go to DONE, issuing no PE beats.
REQ-016 In RUN, op_ready SHALL be 1, pe_rdy SHALL be 1 and pe_val SHALL equal op_valid; in all other states op_ready, pe_val and pe_rdy SHALL be 0.
REQ-017 pe_a/pe_b SHALL equal op_a/op_b combinationally.
REQ-018 pe_acc_in SHALL be 0 while first-flag is set and SHALL be pe_acc_out otherwise.
REQ-019 Each RUN cycle with op_valid=1 is one beat: clear first-flag and decrement the remaining counter.
REQ-020 A RUN cycle with op_valid=0 SHALL change no state; the PE holds acc_out, so the feedback stays correct across bubbles.
REQ-021 The beat taken with remaining=1 SHALL move the FSM to DRAIN.
REQ-022 Beats may be back-to-back: with one-cycle PE latency, pe_acc_out SHALL already hold the previous partial sum.
REQ-023 DRAIN with pe_val_out=1: capture pe_acc_out into res_data and go to DONE.
REQ-024 DRAIN with pe_val_out=0: remain in DRAIN.
REQ-025 DONE SHALL drive res_valid=1 with res_data held stable until res_ready=1, then go to IDLE.
REQ-026 res_valid SHALL be 0 in every state except DONE.
REQ-027 A new cfg SHALL be accepted no earlier than the cycle after the result handshake.
REQ-028 Accumulation SHALL be unsigned, modulo 2^ACC_W, and wrap silently (PE semantics).
REQ-029 Job latency from cfg accept, with no bubbles and res_ready=1: cfg_len + 2 cycles to res_valid (0 stall cycles counted for len=0: res_valid the next cycle).
REQ-030 cfg_valid in a non-IDLE state SHALL be ignored and SHALL NOT disturb the job in progress.

Reset
REQ-031 On reset the FSM SHALL enter IDLE, clear the counter and res_data to 0, and set first-flag.
REQ-032 During reset, outputs SHALL be: cfg_ready=1 on the cycle after reset deasserts, and res_valid=0, op_ready=0, pe_val=0, pe_rdy=0, busy=0 from the reset edge.
REQ-033 Reset in any state SHALL abort the job and discard partial sums; the PE is reset by the same signal.

Verification
REQ-034 cfg_len=3, ops (2,3), (4,5), (6,7) back-to-back -> res_data=68 (0x44), res_valid 5 cycles after cfg accept.
REQ-035 cfg_len=2, ops (10,10), a 3-cycle op_valid gap, then (1,1) -> res_data=101, with no pe_val pulses during the gap.
REQ-036 cfg_len=0 -> res_valid next cycle, res_data=0, and pe_val never asserted.
REQ-037 cfg_len=2, ops (0xFFFF,0xFFFF) twice -> res_data=0xFFFC0002 (wrapped); then res_ready held 0 for 4 cycles -> res_data stable and cfg_ready=0 throughout.
REQ-038 Reset asserted in RUN after 1 of 4 beats, then cfg_len=1 with op (3,3) -> res_data=9, showing no residue from the aborted job.
REQ-039 cfg_valid pulsed during RUN with cfg_len=5 -> ignored; the current job completes with its original length.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: runs one dot-product job on an external registered MAC PE.
// A job is started with cfg_valid/cfg_len, fed cfg_len operand pairs on the
// op_* stream, and finishes with the accumulated sum on the res_* handshake.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cfg_valid/cfg_ready/cfg_len    job start handshake and element count
//   op_valid/op_ready/op_a/op_b    operand stream
//   pe_a/pe_b/pe_acc_in/pe_val/pe_rdy   drive the PE inputs
//   pe_acc_out/pe_val_out          PE accumulator and its valid
//   res_valid/res_ready/res_data   result handshake
//   busy                           high whenever a job is in progress
module mac_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] pe_a,
  output logic [DATA_W-1:0] pe_b,
  output logic [ACC_W-1:0]  pe_acc_in,
  output logic              pe_val,
  output logic              pe_rdy,
  input  logic [ACC_W-1:0]  pe_acc_out,
  input  logic              pe_val_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic [ACC_W-1:0]   res_q, res_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      first_q <= 1'b1;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      res_q   <= res_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    first_d   = first_q;
    res_d     = res_q;
    cfg_ready = 1'b0;
    op_ready  = 1'b0;
    pe_val    = 1'b0;
    pe_rdy    = 1'b0;
    res_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if (cfg_len != '0) begin
            rem_d   = cfg_len;
            first_d = 1'b1;
            state_d = S_RUN;
          end else begin
            // Empty job: result is zero and the PE is never touched
            res_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        op_ready = 1'b1;
        pe_rdy   = 1'b1;
        pe_val   = op_valid;
        // Bubbles leave all state alone; the PE holds its accumulator
        if (op_valid) begin
          first_d = 1'b0;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Wait for the last beat to land in the PE accumulator
        if (pe_val_out) begin
          res_d   = pe_acc_out;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands pass straight through; the first beat of a job starts from zero
  assign pe_a      = op_a;
  assign pe_b      = op_b;
  assign pe_acc_in = first_q ? '0 : pe_acc_out;
  assign res_data  = res_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [LEN_W-1:0]  cfg_len;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] pe_a, pe_b;
  logic [ACC_W-1:0]  pe_acc_in;
  logic              pe_val, pe_rdy;
  logic [ACC_W-1:0]  pe_acc_out;
  logic              pe_val_out;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              busy;

  mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_a(pe_a), .pe_b(pe_b), .pe_acc_in(pe_acc_in), .pe_val(pe_val), .pe_rdy(pe_rdy),
    .pe_acc_out(pe_acc_out), .pe_val_out(pe_val_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered MAC processing element, reset by the same signal
  always @(posedge clk) begin
    if (reset) begin
      pe_acc_out <= '0;
      pe_val_out <= 1'b0;
    end else begin
      pe_val_out <= pe_val && pe_rdy;
      if (pe_val && pe_rdy)
        pe_acc_out <= pe_acc_in + (ACC_W'(pe_a) * ACC_W'(pe_b));
    end
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [ACC_W-1:0] val;
    int beats;
    int acc_cyc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts PE beats per job, checks latency and results against the scoreboard
  int beat_cnt = 0;
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      beat_cnt = 0;
      prev_rv  = 1'b0;
    end else begin
      if (cfg_valid && cfg_ready) beat_cnt = 0;
      if (pe_val && pe_rdy) beat_cnt++;
      if (res_valid && !prev_rv) begin
        if (sb.size() == 0) chk("unexpected_res_valid", 1, 0);
        else if (sb[0].lat >= 0) chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("res_without_job", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_data", 64'(res_data), 64'(e.val));
          chk("pe_beats", 64'(beat_cnt), 64'(e.beats));
        end
      end
      prev_rv = res_valid;
    end
  end

  // Optional random backpressure on the result port
  bit rr_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
  end

  logic [DATA_W-1:0] opa [0:15];
  logic [DATA_W-1:0] opb [0:15];

  task automatic run_job(input int len, input int bub_max, input int gap_at, input int gap_len,
                         input bit pulse_cfg, input int abort_after, input bit hold_rr);
    logic [ACC_W-1:0] sum;
    exp_t e;
    int t;
    sum = '0;
    for (int i = 0; i < len; i++)
      sum = sum + ({16'd0, opa[i]} * {16'd0, opb[i]});
    cfg_valid = 1'b1;
    cfg_len   = LEN_W'(len);
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cfg_ready) break;
    end
    if (t == 200) chk("cfg_accept_timeout", 1, 0);
    e.val = sum; e.beats = len; e.acc_cyc = cyc;
    e.lat = (bub_max == 0 && gap_len == 0) ? ((len == 0) ? 1 : len + 2) : -1;
    sb.push_back(e);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      int nb;
      if (abort_after == i) begin
        // Abort mid-job: hold op_valid high to confirm the PE stays idle in reset
        void'(sb.pop_back());
        reset = 1'b1; op_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_cfg_ready", 64'(cfg_ready), 1);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_op_ready", 64'(op_ready), 0);
        chk("rst_pe_val", 64'(pe_val), 0);
        chk("rst_pe_rdy", 64'(pe_rdy), 0);
        chk("rst_busy", 64'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0; op_valid = 1'b0;
        return;
      end
      nb = (i == gap_at) ? gap_len : ((bub_max > 0) ? int'($urandom_range(0, bub_max)) : 0);
      op_valid = 1'b0;
      repeat (nb) begin
        @(negedge clk);
        chk("gap_no_pe_val", 64'(pe_val), 0);
        @(posedge clk); #1;
      end
      op_valid = 1'b1; op_a = opa[i]; op_b = opb[i];
      if (pulse_cfg && i == 1) begin cfg_valid = 1'b1; cfg_len = LEN_W'(2); end
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (op_ready) break;
      end
      if (t == 200) chk("op_accept_timeout", 1, 0);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
    end
    op_valid = 1'b0;
    if (hold_rr) begin
      rr_rand = 1'b0; res_ready = 1'b0;
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (res_valid) break;
      end
      if (t == 200) chk("res_valid_timeout", 1, 0);
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        chk("hold_res_valid", 64'(res_valid), 1);
        chk("hold_res_data", 64'(res_data), 64'(sum));
        chk("hold_cfg_ready", 64'(cfg_ready), 0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
    end
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (res_valid && res_ready) break;
    end
    if (t == 200) chk("res_handshake_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("init_cfg_ready", 64'(cfg_ready), 1);
    chk("init_busy", 64'(busy), 0);
    chk("init_res_valid", 64'(res_valid), 0);
    chk("init_op_ready", 64'(op_ready), 0);
    chk("init_pe_rdy", 64'(pe_rdy), 0);
    chk("init_res_data", 64'(res_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back three-element job -> 68
    opa[0] = 2; opb[0] = 3; opa[1] = 4; opb[1] = 5; opa[2] = 6; opb[2] = 7;
    run_job(3, 0, -1, 0, 0, -1, 0);
    // Three-cycle operand gap -> 101
    opa[0] = 10; opb[0] = 10; opa[1] = 1; opb[1] = 1;
    run_job(2, 0, 1, 3, 0, -1, 0);
    // Empty job
    run_job(0, 0, -1, 0, 0, -1, 0);
    // Wraparound plus result backpressure
    opa[0] = 16'hFFFF; opb[0] = 16'hFFFF; opa[1] = 16'hFFFF; opb[1] = 16'hFFFF;
    run_job(2, 0, -1, 0, 0, -1, 1);
    // Abort after one beat, then a fresh single-element job -> 9
    for (int i = 0; i < 4; i++) begin opa[i] = 16'(100 + i); opb[i] = 16'(7 + i); end
    run_job(4, 0, -1, 0, 0, 1, 0);
    opa[0] = 3; opb[0] = 3;
    run_job(1, 0, -1, 0, 0, -1, 0);
    // Stray cfg during a five-element job
    for (int i = 0; i < 5; i++) begin opa[i] = 16'(i + 1); opb[i] = 16'(2 * i + 3); end
    run_job(5, 0, -1, 0, 1, -1, 0);

    // Random jobs with bubbles and result backpressure
    for (int j = 0; j < 30; j++) begin
      int len;
      len = int'($urandom_range(0, 10));
      for (int i = 0; i < len; i++) begin
        opa[i] = 16'($urandom); opb[i] = 16'($urandom);
      end
      rr_rand = ($urandom_range(0, 1) == 1);
      run_job(len, (j % 3 == 0) ? 0 : 2, -1, 0, (len >= 2) && (j % 5 == 0), -1, 0);
      rr_rand = 1'b0; res_ready = 1'b1;
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
